// File: rtl/writeback_stage_pkg.sv
// Shared core types for the writeback stage: load size encoding, writeback
// FSM states and the register-bank one-hot write-enable helper.
package writeback_stage_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned REG_IDX_W = 5;

    typedef enum logic [1:0] {
        LB_SZ = 2'b00,
        LH_SZ = 2'b01,
        LW_SZ = 2'b10
    } load_size_e;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        WAIT_MEM = 2'b01,
        WRITE    = 2'b10
    } wb_state_e;

    // One-hot write enable over x1..x31; x0 has no enable bit, so rd = 0 yields all-zero.
    function automatic logic [31:1] rd_onehot(input logic [REG_IDX_W-1:0] rd);
        logic [31:1] oh;
        oh = '0;
        for (int i = 1; i < 32; i++) begin
            if (rd == REG_IDX_W'(i)) begin
                oh[i] = 1'b1;
            end
        end
        return oh;
    endfunction

endpackage

// File: rtl/writeback_stage_if.sv
// Writeback-stage bus: execute handshake, data-memory response, register-bank
// write port and the forwarding / pending-load view for decode.
interface writeback_stage_if;
    import writeback_stage_pkg::*;

    logic                 ex_valid;
    logic                 ex_ready;
    logic [4:0]           ex_rd;
    logic [XLEN-1:0]      ex_result;
    logic                 ex_is_load;
    load_size_e           ex_ld_size;
    logic                 ex_ld_unsigned;
    logic [1:0]           ex_addr_lsb;

    logic                 mem_rvalid;
    logic [XLEN-1:0]      mem_rdata;

    logic [31:1]          rf_addrw;
    logic [XLEN-1:0]      rf_wdata;

    logic                 fwd_valid;
    logic [4:0]           fwd_rd;
    logic                 ld_pending;
    logic [4:0]           ld_rd;
    logic                 retire;

    // Upstream / environment side: execute, data memory, and consumers of the write port.
    modport master (
        output ex_valid, ex_rd, ex_result, ex_is_load, ex_ld_size, ex_ld_unsigned, ex_addr_lsb,
        output mem_rvalid, mem_rdata,
        input  ex_ready, rf_addrw, rf_wdata, fwd_valid, fwd_rd, ld_pending, ld_rd, retire
    );

    // Writeback stage side.
    modport slave (
        input  ex_valid, ex_rd, ex_result, ex_is_load, ex_ld_size, ex_ld_unsigned, ex_addr_lsb,
        input  mem_rvalid, mem_rdata,
        output ex_ready, rf_addrw, rf_wdata, fwd_valid, fwd_rd, ld_pending, ld_rd, retire
    );

endinterface

// File: rtl/writeback_stage_load_aligner.sv
// Combinational load alignment: picks the addressed byte/half lane out of the
// word-aligned memory data and sign- or zero-extends it to 32 bits.
module writeback_stage_load_aligner
    import writeback_stage_pkg::*;
(
    input  logic [XLEN-1:0] rdata,
    input  load_size_e      size,
    input  logic            is_unsigned,
    input  logic [1:0]      lsb,
    output logic [XLEN-1:0] value
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    // Lane selection; half-word ignores lsb[0] since misaligned halves never get here.
    always_comb begin
        byte_lane = rdata[7:0];
        case (lsb)
            2'd0:    byte_lane = rdata[7:0];
            2'd1:    byte_lane = rdata[15:8];
            2'd2:    byte_lane = rdata[23:16];
            default: byte_lane = rdata[31:24];
        endcase
        half_lane = lsb[1] ? rdata[31:16] : rdata[15:0];
    end

    // Extension; word loads pass through untouched regardless of the unsigned flag.
    always_comb begin
        value = rdata;
        case (size)
            LB_SZ:   value = {{24{byte_lane[7]  & ~is_unsigned}}, byte_lane};
            LH_SZ:   value = {{16{half_lane[15] & ~is_unsigned}}, half_lane};
            default: value = rdata;
        endcase
    end

endmodule

// File: rtl/writeback_stage.sv
// Writeback stage: retires ops from execute, waits for load data, and is the
// sole writer of the register bank. One write per cycle is sustainable.
//
//  state    | meaning
//  ---------+--------------------------------------------------------------
//  IDLE     | nothing to write; ready for a new op
//  WAIT_MEM | load accepted, waiting for mem_rvalid; execute is stalled
//  WRITE    | staged result is driven to the register bank this cycle only;
//           | a new op may be accepted in the same cycle
module writeback_stage
    import writeback_stage_pkg::*;
#(
    parameter int DEBUG = 0
) (
    input  logic               clk,
    input  logic               reset,
    writeback_stage_if.slave   bus
);

    wb_state_e             state_q;
    wb_state_e             state_d;

    logic [4:0]            rd_q;
    logic [XLEN-1:0]       wdata_q;
    load_size_e            size_q;
    logic                  uns_q;
    logic [1:0]            lsb_q;

    logic                  accept;
    logic                  mem_take;
    logic [XLEN-1:0]       aligned;

    assign bus.ex_ready = (state_q != WAIT_MEM);
    assign accept       = bus.ex_valid && bus.ex_ready;
    assign mem_take     = (state_q == WAIT_MEM) && bus.mem_rvalid;

    writeback_stage_load_aligner u_load_aligner (
        .rdata       (bus.mem_rdata),
        .size        (size_q),
        .is_unsigned (uns_q),
        .lsb         (lsb_q),
        .value       (aligned)
    );

    // State register; reset drops any pending load without writing.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: IDLE and WRITE share the accept transitions so writes can run back to back.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, WRITE: begin
                if (accept) begin
                    state_d = bus.ex_is_load ? WAIT_MEM : WRITE;
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT_MEM: begin
                if (bus.mem_rvalid) begin
                    state_d = WRITE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Staging registers: capture the op at accept, the aligned load data at response.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_q    <= '0;
            wdata_q <= '0;
            size_q  <= LB_SZ;
            uns_q   <= 1'b0;
            lsb_q   <= '0;
        end else if (accept) begin
            rd_q <= bus.ex_rd;
            if (bus.ex_is_load) begin
                size_q <= bus.ex_ld_size;
                uns_q  <= bus.ex_ld_unsigned;
                lsb_q  <= bus.ex_addr_lsb;
            end else begin
                wdata_q <= bus.ex_result;
            end
        end else if (mem_take) begin
            wdata_q <= aligned;
        end
    end

    // All outputs derive from registered state only, keeping ex_*/mem_* off any path to rf_*.
    assign bus.rf_addrw   = (state_q == WRITE) ? rd_onehot(rd_q) : '0;
    assign bus.rf_wdata   = wdata_q;
    assign bus.fwd_valid  = (state_q == WRITE) && (rd_q != 5'd0);
    assign bus.fwd_rd     = rd_q;
    assign bus.ld_pending = (state_q == WAIT_MEM);
    assign bus.ld_rd      = (state_q == WAIT_MEM) ? rd_q : 5'd0;
    assign bus.retire     = (state_q == WRITE);

    if (DEBUG != 0) begin : g_debug
        // Debug-only consistency checks on the write port; absent from normal builds.
        always_comb begin
            assert (!bus.fwd_valid || $onehot(bus.rf_addrw));
            assert ((state_q == WRITE) || (bus.rf_addrw == '0));
        end
    end

endmodule
